booth_r8_datapath: RTL and testbench

Radix-8 Booth multiplier datapath. It is the responding end of the Load/Add/Addc/Shift control strobe interface, and it returns Product and the A/B/C observation buses. It performs unsigned n×n multiplication in ceil((n+1)/3) add/shift iterations. The recoded Booth digit is exported so a controller FSM or the stimulus bench can choose Add or Addc each iteration.

---
 rtl/booth_r8_pkg.sv | 41 ++++
 rtl/booth_r8_recode.sv | 21 ++
 rtl/booth_r8_datapath.sv | 112 +++++++++++
 tb/tb_booth_r8_datapath.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/booth_r8_pkg.sv
// Shared widths, digit magnitude encoding and radix-8 Booth recode for booth_r8_datapath.
package booth_r8_pkg;

  localparam logic [2:0] MAG_0 = 3'd0;
  localparam logic [2:0] MAG_1 = 3'd1;
  localparam logic [2:0] MAG_2 = 3'd2;
  localparam logic [2:0] MAG_3 = 3'd3;
  localparam logic [2:0] MAG_4 = 3'd4;

  typedef struct packed {
    logic       neg;
    logic [2:0] mag;
  } digit_t;

  function automatic int unsigned qw_of(input int unsigned n);
    return 3 * ((n + 3) / 3);
  endfunction

  function automatic int unsigned aw_of(input int unsigned n);
    return n + 3;
  endfunction

  // d = -4*q[2] + 2*q[1] + q[0] + g, returned as sign and magnitude
  function automatic digit_t recode(input logic [2:0] q3, input logic g);
    digit_t d;
    d = '{neg: 1'b0, mag: MAG_0};
    case ({q3, g})
      4'b0001, 4'b0010: d = '{neg: 1'b0, mag: MAG_1};
      4'b0011, 4'b0100: d = '{neg: 1'b0, mag: MAG_2};
      4'b0101, 4'b0110: d = '{neg: 1'b0, mag: MAG_3};
      4'b0111:          d = '{neg: 1'b0, mag: MAG_4};
      4'b1000:          d = '{neg: 1'b1, mag: MAG_4};
      4'b1001, 4'b1010: d = '{neg: 1'b1, mag: MAG_3};
      4'b1011, 4'b1100: d = '{neg: 1'b1, mag: MAG_2};
      4'b1101, 4'b1110: d = '{neg: 1'b1, mag: MAG_1};
      default:          d = '{neg: 1'b0, mag: MAG_0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r8_recode.sv
// Combinational radix-8 Booth digit recoder: sign, zero flag and magnitude code.
module booth_r8_recode
  import booth_r8_pkg::*;
(
  input  logic [2:0] q_i,
  input  logic       g_i,
  output logic       dneg_c_o,
  output logic       dzero_c_o,
  output logic [2:0] mag_c_o
);

  digit_t digit;

  always_comb begin
    digit     = recode(q_i, g_i);
    dneg_c_o  = digit.neg;
    dzero_c_o = (digit.mag == MAG_0);
    mag_c_o   = digit.mag;
  end

endmodule

// File: rtl/booth_r8_datapath.sv
// Radix-8 Booth multiplier datapath driven by Load/Add/Addc/Shift strobes.
module booth_r8_datapath
  import booth_r8_pkg::*;
#(
  parameter int unsigned n = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [n-1:0]   Mplier,
  input  logic [n-1:0]   Mplicand,
  input  logic           Load,
  input  logic           Add,
  input  logic           Addc,
  input  logic           Shift,
  output logic [2*n-1:0] Product,
  output logic [n:0]     A,
  output logic [n:0]     B,
  output logic [n:0]     C,
  output logic           Dneg,
  output logic           Dzero,
  output logic           Done
);

  localparam int unsigned QW = qw_of(n);
  localparam int unsigned AW = aw_of(n);
  localparam int unsigned ND = QW / 3;
  localparam int unsigned CW = $clog2(ND + 1);

  logic [n-1:0]     m_q,   m_d;
  logic [n+1:0]     m3_q,  m3_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [QW-1:0]    q_q,   q_d;
  logic             g_q,   g_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [2:0]       mag_code;
  logic [AW-1:0]    mag;
  logic [AW+QW-1:0] accq;

  booth_r8_recode u_recode (
    .q_i       (q_q[2:0]),
    .g_i       (g_q),
    .dneg_c_o  (Dneg),
    .dzero_c_o (Dzero),
    .mag_c_o   (mag_code)
  );

  assign Done    = (cnt_q == CW'(ND));
  assign accq    = {acc_q, q_q};
  assign Product = accq[2*n-1:0];
  assign A       = acc_q[n:0];
  assign B       = q_q[n:0];
  assign C       = m3_q[n:0];

  // Multiple of M selected by the current digit, zero-extended to the accumulator
  always_comb begin
    mag = '0;
    case (mag_code)
      MAG_1:   mag = AW'(m_q);
      MAG_2:   mag = AW'({m_q, 1'b0});
      MAG_3:   mag = AW'(m3_q);
      MAG_4:   mag = AW'({m_q, 2'b00});
      default: mag = '0;
    endcase
  end

  // Strobe priority Load > Add > Addc > Shift; Shift is ignored once Done
  always_comb begin
    m_d   = m_q;
    m3_d  = m3_q;
    acc_d = acc_q;
    q_d   = q_q;
    g_d   = g_q;
    cnt_d = cnt_q;
    if (Load) begin
      m_d   = Mplicand;
      m3_d  = (n+2)'(Mplicand) + (n+2)'({Mplicand, 1'b0});
      acc_d = '0;
      q_d   = QW'(Mplier);
      g_d   = 1'b0;
      cnt_d = '0;
    end else if (Add) begin
      acc_d = acc_q + mag;
    end else if (Addc) begin
      acc_d = acc_q + ~mag + AW'(1);
    end else if (Shift && !Done) begin
      acc_d = {{3{acc_q[AW-1]}}, acc_q[AW-1:3]};
      q_d   = {acc_q[2:0], q_q[QW-1:3]};
      g_d   = q_q[2];
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_q   <= '0;
      m3_q  <= '0;
      acc_q <= '0;
      q_q   <= '0;
      g_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      m_q   <= m_d;
      m3_q  <= m3_d;
      acc_q <= acc_d;
      q_q   <= q_d;
      g_q   <= g_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_booth_r8_datapath.sv
// Directed bench for booth_r8_datapath with hand-computed expected values.
module tb_booth_r8_datapath;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  Mplier = '0;
  logic [7:0]  Mplicand = '0;
  logic        Load = 1'b0;
  logic        Add = 1'b0;
  logic        Addc = 1'b0;
  logic        Shift = 1'b0;
  logic [15:0] Product;
  logic [8:0]  A;
  logic [8:0]  B;
  logic [8:0]  C;
  logic        Dneg;
  logic        Dzero;
  logic        Done;

  int n_vec = 0;
  int n_err = 0;

  booth_r8_datapath #(.n(8)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Mplier   (Mplier),
    .Mplicand (Mplicand),
    .Load     (Load),
    .Add      (Add),
    .Addc     (Addc),
    .Shift    (Shift),
    .Product  (Product),
    .A        (A),
    .B        (B),
    .C        (C),
    .Dneg     (Dneg),
    .Dzero    (Dzero),
    .Done     (Done)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic ld, input logic ad, input logic ac, input logic sh);
    Load = ld; Add = ad; Addc = ac; Shift = sh;
    tick();
    Load = 1'b0; Add = 1'b0; Addc = 1'b0; Shift = 1'b0;
  endtask

  // Simple controller: one add/subtract by digit sign, then a shift, per digit
  task automatic run_mult(input logic [7:0] mp, input logic [7:0] mc);
    Mplier = mp; Mplicand = mc;
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (Dneg) strobe(1'b0, 1'b0, 1'b1, 1'b0);
      else      strobe(1'b0, 1'b1, 1'b0, 1'b0);
      strobe(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    // Reset between edges clears everything at once
    tick(); tick();
    Mplier = 8'd10; Mplicand = 8'd10;
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_B", 32'(B), 32'd10);
    #3 Reset = 1'b0;
    #1;
    chk("rst_product", 32'(Product), 32'd0);
    chk("rst_ABC", 32'({A, B, C}), 32'd0);
    chk("rst_flags", 32'({Done, Dneg, Dzero}), 32'b001);
    #2 Reset = 1'b1;
    repeat (5) tick();
    chk("idle_hold", 32'({Product, C, Done, Dzero}), 32'b01);

    // 20 x 120: digits -4, +3, 0
    Mplier = 8'd20; Mplicand = 8'd120;
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t20_C", 32'(C), 32'd360);
    chk("t20_d0", 32'({Dneg, Dzero, Done}), 32'b100);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t20_A_sub", 32'(A), 32'd32);
    strobe(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t20_d1", 32'({Dneg, Dzero}), 32'b00);
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t20_d2", 32'({Dneg, Dzero}), 32'b01);
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t20_not_done", 32'(Done), 32'd0);
    strobe(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t20_done", 32'(Done), 32'd1);
    chk("t20_product", 32'(Product), 32'h0960);

    // 255 x 255: digits -1, 0, +4
    Mplier = 8'd255; Mplicand = 8'd255;
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t255_C", 32'(C), 32'd253);
    chk("t255_d0", 32'({Dneg, Dzero}), 32'b10);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t255_d1", 32'({Dneg, Dzero}), 32'b01);
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t255_d2", 32'({Dneg, Dzero}), 32'b00);
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t255_done", 32'(Done), 32'd1);
    chk("t255_product", 32'(Product), 32'hFE01);

    // Zero multiplier: every digit zero, extra Shift after Done is ignored
    Mplier = 8'd0; Mplicand = 8'd200;
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("zero_digit", 32'({Dzero, Done}), 32'b10);
      strobe(1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("zero_done", 32'({Done, Product}), 32'h10000);
    strobe(1'b0, 1'b0, 1'b0, 1'b1);
    chk("zero_extra_shift", 32'({Done, Product}), 32'h10000);

    // Priority: Load wins over Add/Shift; Add wins over Shift
    Mplier = 8'd7; Mplicand = 8'd9;
    strobe(1'b1, 1'b1, 1'b0, 1'b1);
    chk("prio_load", 32'({A, B}), 32'({9'd0, 9'd7}));
    chk("prio_load_done", 32'(Done), 32'd0);
    strobe(1'b0, 1'b1, 1'b0, 1'b1);
    chk("prio_add", 32'({A, B}), 32'({9'd9, 9'd7}));
    chk("prio_add_digit", 32'(Dneg), 32'd1);

    // Reset mid-sequence, then a clean 13 x 11
    Mplier = 8'd13; Mplicand = 8'd11;
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b0, 1'b1);
    #3 Reset = 1'b0;
    #1;
    chk("mid_rst", 32'({Product, A}), 32'd0);
    chk("mid_rst_flags", 32'({C, Dzero, Dneg, Done}), 32'b0100);
    #2 Reset = 1'b1;
    run_mult(8'd13, 8'd11);
    chk("t13_done", 32'(Done), 32'd1);
    chk("t13_product", 32'(Product), 32'd143);

    run_mult(8'd170, 8'd85);
    chk("t170_product", 32'(Product), 32'd14450);
    run_mult(8'd255, 8'd1);
    chk("t255x1_product", 32'(Product), 32'd255);
    run_mult(8'd1, 8'd255);
    chk("t1x255_product", 32'(Product), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
